// File: rtl/encode_dense_cmd_if.sv
// ----------------------------------------------------------------------------
// encode_dense_cmd_if
//
// Bundles every signal that crosses the encode_dense_cmd boundary, apart from
// clk and rst_n. It carries two handshakes:
//   - the beat stream from the host load path: in_data / in_valid / in_ready
//   - the assembled dense command towards the decode stage: cmd_valid /
//     cmd_ready plus the bundle fields.
//
// Modports:
//   master : the encoder. It consumes beats and issues the command bundle.
//            It drives in_ready, cmd_valid and all *_out fields.
//   slave  : the surroundings, i.e. host plus decode stage. It drives
//            in_data, in_valid and cmd_ready.
//
// Vector fields (w_out, x_out, label_out) hold element i at
// bits [i*data_size +: data_size].
// ----------------------------------------------------------------------------
interface encode_dense_cmd_if #(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int cost_type_size         = 8,
    parameter int dense_type_size        = 4,
    parameter int act_type_size          = 4,
    parameter int backprop_controll_size = 66
);
    // beat stream (host -> encoder)
    logic [data_size-1:0]              in_data;
    logic                              in_valid;
    logic                              in_ready;

    // command bundle (encoder -> decode stage)
    logic                              cmd_valid;
    logic                              cmd_ready;
    logic [act_type_size-1:0]          act_type_out;
    logic [dense_type_size-1:0]        dense_type_out;
    logic [cost_type_size-1:0]         cost_type_out;
    logic [size*data_size-1:0]         w_out;
    logic                              load_w_out;
    logic [size*data_size-1:0]         x_out;
    logic [size*data_size-1:0]         label_out;
    logic [backprop_controll_size-1:0] backprop_controll_out;

    modport master (
        input  in_data, in_valid, cmd_ready,
        output in_ready, cmd_valid,
        output act_type_out, dense_type_out, cost_type_out,
        output w_out, load_w_out, x_out, label_out, backprop_controll_out
    );

    modport slave (
        output in_data, in_valid, cmd_ready,
        input  in_ready, cmd_valid,
        input  act_type_out, dense_type_out, cost_type_out,
        input  w_out, load_w_out, x_out, label_out, backprop_controll_out
    );
endinterface

// File: rtl/encode_dense_cmd.sv
// ----------------------------------------------------------------------------
// encode_dense_cmd
//
// Host-side command encoder for the dense-layer datapath. It collects a
// stream of data_size-bit beats into one dense command and hands the bundle
// to the decode-stage register over a valid/ready handshake.
//
// Beat order of one command:
//   HDR   : act / dense / cost type fields, packed from bit 0 upwards
//   FLAGS : bit0 load_w, bit1 has_label, bit2 has_bp
//   W     : size beats, only when load_w
//   X     : size beats, always
//   LABEL : size beats, only when has_label
//   BP    : ceil(backprop_controll_size/data_size) beats, only when has_bp
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset; clears state and every field
//   bus    : encode_dense_cmd_if.master
//            in_data/in_valid/in_ready  beat handshake
//            cmd_valid/cmd_ready        bundle handshake
//            *_out                      bundle fields
// ----------------------------------------------------------------------------
module encode_dense_cmd #(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int cost_type_size         = 8,
    parameter int dense_type_size        = 4,
    parameter int act_type_size          = 4,
    parameter int backprop_controll_size = 66
) (
    input  logic                clk,
    input  logic                rst_n,
    encode_dense_cmd_if.master  bus
);

    localparam int VEC_W     = size * data_size;
    localparam int BP_BEATS  = (backprop_controll_size + data_size - 1) / data_size;
    localparam int BP_EXT_W  = BP_BEATS * data_size;
    localparam int MAX_BEATS = (size > BP_BEATS) ? size : BP_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_FLAGS,
        S_W,
        S_X,
        S_LABEL,
        S_BP,
        S_ISSUE
    } state_e;

    // ------------------------------------------------------------------------
    // Registers (q) and their next values (d)
    // ------------------------------------------------------------------------
    state_e                            state_q,     state_d;
    logic [CNT_W-1:0]                  beat_cnt_q,  beat_cnt_d;
    logic                              in_ready_q,  in_ready_d;
    logic                              cmd_valid_q, cmd_valid_d;
    logic                              has_label_q, has_label_d;
    logic                              has_bp_q,    has_bp_d;

    logic [act_type_size-1:0]          act_q,       act_d;
    logic [dense_type_size-1:0]        dense_q,     dense_d;
    logic [cost_type_size-1:0]         cost_q,      cost_d;
    logic [VEC_W-1:0]                  w_q,         w_d;
    logic                              load_w_q,    load_w_d;
    logic [VEC_W-1:0]                  x_q,         x_d;
    logic [VEC_W-1:0]                  label_q,     label_d;
    logic [backprop_controll_size-1:0] bp_q,        bp_d;

    logic accept;
    logic last_vec_beat;
    logic last_bp_beat;

    // Write one element of a packed vector. The loop keeps every part-select
    // index constant, which synthesises to a plain per-element enable.
    function automatic logic [VEC_W-1:0] put_elem(
        input logic [VEC_W-1:0]     vec,
        input logic [CNT_W-1:0]     idx,
        input logic [data_size-1:0] val
    );
        logic [VEC_W-1:0] res;
        res = vec;
        for (int j = 0; j < size; j++) begin
            if (int'(idx) == j) begin
                res[j*data_size +: data_size] = val;
            end
        end
        return res;
    endfunction

    // Write one backprop beat. The bundle is widened to a whole number of
    // beats so the last beat can be written in full; whatever lands at or
    // above backprop_controll_size is then dropped by the narrowing.
    function automatic logic [backprop_controll_size-1:0] put_bp(
        input logic [backprop_controll_size-1:0] vec,
        input logic [CNT_W-1:0]                  idx,
        input logic [data_size-1:0]              val
    );
        logic [BP_EXT_W-1:0] ext;
        ext = BP_EXT_W'(vec);
        for (int k = 0; k < BP_BEATS; k++) begin
            if (int'(idx) == k) begin
                ext[k*data_size +: data_size] = val;
            end
        end
        return ext[backprop_controll_size-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Next-state and field-update logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        has_label_d = has_label_q;
        has_bp_d    = has_bp_q;
        act_d       = act_q;
        dense_d     = dense_q;
        cost_d      = cost_q;
        w_d         = w_q;
        load_w_d    = load_w_q;
        x_d         = x_q;
        label_d     = label_q;
        bp_d        = bp_q;

        // in_ready_q is already 0 in ISSUE and during the first cycle after
        // reset release, so it alone qualifies the beat handshake.
        accept        = bus.in_valid && in_ready_q;
        last_vec_beat = (beat_cnt_q == CNT_W'(size - 1));
        last_bp_beat  = (beat_cnt_q == CNT_W'(BP_BEATS - 1));

        unique case (state_q)
            S_HDR: begin
                if (accept) begin
                    act_d   = bus.in_data[0 +: act_type_size];
                    dense_d = bus.in_data[act_type_size +: dense_type_size];
                    cost_d  = bus.in_data[act_type_size + dense_type_size +: cost_type_size];
                    state_d = S_FLAGS;
                end
            end

            S_FLAGS: begin
                if (accept) begin
                    load_w_d    = bus.in_data[0];
                    has_label_d = bus.in_data[1];
                    has_bp_d    = bus.in_data[2];
                    // Optional sections that are absent must not leak stale
                    // data from the previous command; weights are the
                    // exception and are deliberately retained.
                    if (!bus.in_data[1]) label_d = '0;
                    if (!bus.in_data[2]) bp_d    = '0;
                    state_d = bus.in_data[0] ? S_W : S_X;
                end
            end

            S_W: begin
                if (accept) begin
                    w_d = put_elem(w_q, beat_cnt_q, bus.in_data);
                    if (last_vec_beat) state_d = S_X;
                end
            end

            S_X: begin
                if (accept) begin
                    x_d = put_elem(x_q, beat_cnt_q, bus.in_data);
                    if (last_vec_beat) begin
                        if (has_label_q)   state_d = S_LABEL;
                        else if (has_bp_q) state_d = S_BP;
                        else               state_d = S_ISSUE;
                    end
                end
            end

            S_LABEL: begin
                if (accept) begin
                    label_d = put_elem(label_q, beat_cnt_q, bus.in_data);
                    if (last_vec_beat) state_d = has_bp_q ? S_BP : S_ISSUE;
                end
            end

            S_BP: begin
                if (accept) begin
                    bp_d = put_bp(bp_q, beat_cnt_q, bus.in_data);
                    if (last_bp_beat) state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (cmd_valid_q && bus.cmd_ready) state_d = S_HDR;
            end

            default: state_d = S_HDR;
        endcase

        // Counter restarts on every state entry, so each section indexes its
        // beats from zero without any explicit wrap.
        if (state_d != state_q) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
            beat_cnt_d = beat_cnt_q;
        end

        // Handshake outputs are registered from the next state, so cmd_valid
        // rises together with the ISSUE entry, one cycle after the last beat.
        in_ready_d  = (state_d != S_ISSUE);
        cmd_valid_d = (state_d == S_ISSUE);
    end

    // ------------------------------------------------------------------------
    // State and field registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR;
            beat_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            has_label_q <= 1'b0;
            has_bp_q    <= 1'b0;
            act_q       <= '0;
            dense_q     <= '0;
            cost_q      <= '0;
            w_q         <= '0;
            load_w_q    <= 1'b0;
            x_q         <= '0;
            label_q     <= '0;
            bp_q        <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            in_ready_q  <= in_ready_d;
            cmd_valid_q <= cmd_valid_d;
            has_label_q <= has_label_d;
            has_bp_q    <= has_bp_d;
            act_q       <= act_d;
            dense_q     <= dense_d;
            cost_q      <= cost_d;
            w_q         <= w_d;
            load_w_q    <= load_w_d;
            x_q         <= x_d;
            label_q     <= label_d;
            bp_q        <= bp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready              = in_ready_q;
    assign bus.cmd_valid             = cmd_valid_q;
    assign bus.act_type_out          = act_q;
    assign bus.dense_type_out        = dense_q;
    assign bus.cost_type_out         = cost_q;
    assign bus.w_out                 = w_q;
    assign bus.load_w_out            = load_w_q;
    assign bus.x_out                 = x_q;
    assign bus.label_out             = label_q;
    assign bus.backprop_controll_out = bp_q;

endmodule

// File: doc/encode_dense_cmd.md
Name: encode_dense_cmd

Overview:
- Host-side command encoder and issuer for the dense-layer datapath. It is the transmit end of the decode-stage register.
- Accepts a stream of data_size-bit beats over a valid/ready handshake and assembles them into one complete dense command: activation/dense/cost types, optional weights, inputs, optional labels and optional backprop control.
- Presents the assembled bundle to the decode register with a valid/ready handshake.
- Sits between the host load interface and the decode stage.

Parameters:
- size, 3, number of vector elements in w, x and label.
- data_size, 16, bits per beat and per vector element.
- cost_type_size, 8, cost-type field width.
- dense_type_size, 4, dense-type field width.
- act_type_size, 4, activation-type field width.
- backprop_controll_size, 66, backprop control bundle width (1+1+32+32).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  data_size  command beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  encoder accepts a beat.
- cmd_valid  out  1  bundle valid.
- cmd_ready  in  1  decode stage accepts the bundle.
- act_type_out  out  act_type_size  activation type.
- dense_type_out  out  dense_type_size  dense type.
- cost_type_out  out  cost_type_size  cost type.
- w_out  out  data_size*size  weights; element i is at bits [i*data_size +: data_size].
- load_w_out  out  1  weight-load strobe qualifier.
- x_out  out  data_size*size  inputs; same packing as w_out.
- label_out  out  data_size*size  labels; same packing as w_out.
- backprop_controll_out  out  backprop_controll_size  backprop control.

Behaviour:
- Beat transfer occurs on a rising clk edge with in_valid && in_ready. Bundle transfer occurs with cmd_valid && cmd_ready.
- BP_BEATS = ceil(backprop_controll_size/data_size), which is 5 at the defaults.
- Command beat order:
  1. HDR: bits [act_type_size-1:0] = act, next dense_type_size bits = dense, next cost_type_size bits = cost. Any bits above are ignored.
  2. FLAGS: bit0 = load_w, bit1 = has_label, bit2 = has_bp. Other bits are ignored.
  3. W: size beats, present only when load_w=1.
  4. X: size beats, always present.
  5. LABEL: size beats, present only when has_label=1.
  6. BP: BP_BEATS beats, present only when has_bp=1. Beat k fills bits [k*data_size +: data_size]. Bits at or above backprop_controll_size are discarded.
- Within W, X and LABEL, beat j writes element j.
- FSM states: HDR, FLAGS, W, X, LABEL, BP, ISSUE.
  - HDR→FLAGS on beat.
  - FLAGS→W if load_w, else →X.
  - W→X after the size-th beat.
  - X→LABEL if has_label, else BP if has_bp, else ISSUE. Taken after the size-th beat.
  - LABEL→BP if has_bp, else ISSUE. Taken after the size-th beat.
  - BP→ISSUE after beat BP_BEATS.
  - ISSUE→HDR on bundle transfer.
- beat_cnt counts beats within W, X, LABEL and BP. It is cleared on every state entry and wraps nowhere: each state exits exactly at its last beat.
- in_ready is 1 in every state except ISSUE; there it is 0.
- cmd_valid is 1 only in ISSUE. All bundle outputs are stable while cmd_valid=1 && cmd_ready=0.
- Fields are updated directly by beats. Outputs may change outside ISSUE; consumers qualify with cmd_valid.
- Field rules per command:
  - w_out is retained from the previous command when load_w=0. load_w_out equals the FLAGS bit.
  - label_out is cleared to 0 at FLAGS when has_label=0.
  - backprop_controll_out is cleared to 0 at FLAGS when has_bp=0.
  - x_out is always fully rewritten.
- Latency: cmd_valid rises the cycle after the last beat of the command is accepted.
- Minimum command is 2+size beats. Maximum is 2+3*size+BP_BEATS beats, which is 16 at the defaults.
- Throughput: one idle input cycle per command (the ISSUE cycle with cmd_ready=1). The next HDR beat is accepted in the cycle after the bundle transfer.
- in_valid=0 mid-command: the FSM holds and nothing is lost.
- Reset (rst_n=0, any time, including mid-command or in ISSUE):
  - state=HDR, beat_cnt=0, cmd_valid=0, in_ready=0 while reset is asserted.
  - All bundle outputs are 0.
  - Any partial command is discarded.
  - in_ready=1 from the first clock edge after release.

Test Plan:
- Minimal command: HDR 0x0521, FLAGS 0x0000, X 0x0010, 0x0020, 0x0030 with cmd_ready=1. Required: cmd_valid pulses 1 cycle; act=1, dense=2, cost=0x05; x_out=0x0030_0020_0010; load_w_out=0; label_out=0; bp=0.
- Full command: FLAGS 0x0007; W 1,2,3; X 4,5,6; L 7,8,9; BP 0xAAAA,0xBBBB,0xCCCC,0xDDDD,0x0003. Required: w_out=0x0003_0002_0001; label_out=0x0009_0008_0007; bp=66'h3_DDDD_CCCC_BBBB_AAAA; 16 beats accepted.
- Backpressure: cmd_ready=0 for 5 cycles after the bundle is assembled. Required: in_ready=0, cmd_valid=1 and outputs constant throughout; transfer occurs on the first cycle cmd_ready=1; next HDR accepted the following cycle.
- Weight retention: command with load_w=1, W=9,9,9, then a command with FLAGS=0. Required: second bundle has w_out=0x0009_0009_0009 and load_w_out=0.
- Input gaps: in_valid toggles 1/0 every cycle through a minimal command. Required: identical bundle to the first scenario; cmd_valid one cycle after the last beat.
- Reset mid-command: assert rst_n=0 after W beat 2, then send a fresh minimal command. Required: all outputs 0 during reset; the fresh command issues correctly with no leftover W data.
